// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors round controller: gestures,
// round results, match winner and controller state codes.
package rps_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_DRAW = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_NC   = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    WN_NONE = 2'b00,
    WN_P1   = 2'b01,
    WN_P2   = 2'b10
  } winner_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_COLLECT = 3'd3,
    ST_JUDGE   = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

endpackage

// File: rtl/rps_round_ctrl_if.sv
// Player/timer/result bundle between the round controller and its environment.
interface rps_round_ctrl_if #(
  parameter int SCORE_W = 4
);
  // Handshake: every *_valid (and start) is a single-cycle qualifier sampled on
  // posedge clk; there is no ready, the controller ignores anything it cannot use.
  logic               start;
  logic [1:0]         p1_move;
  logic [1:0]         p2_move;
  logic               p1_valid;
  logic               p2_valid;
  logic               timer_done;
  logic               timer_in;
  logic               timer_clr;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [1:0]         round_result;
  logic               result_valid;
  logic               match_over;
  logic [1:0]         winner;
  logic [2:0]         dbg_state;

  modport master (
    output start, p1_move, p2_move, p1_valid, p2_valid, timer_done,
    input  timer_in, timer_clr, score1, score2, round_result, result_valid,
           match_over, winner, dbg_state
  );

  modport slave (
    input  start, p1_move, p2_move, p1_valid, p2_valid, timer_done,
    output timer_in, timer_clr, score1, score2, round_result, result_valid,
           match_over, winner, dbg_state
  );
endinterface

// File: rtl/rps_judge.sv
// Pure combinational referee: two gestures in, round result out.
// A missing gesture on either side yields no-contest.
module rps_judge
  import rps_pkg::*;
(
  input  move_t   a_i,
  input  move_t   b_i,
  output result_t result_o
);

  always_comb begin
    result_o = RES_P2;
    if (a_i == MV_NONE || b_i == MV_NONE) begin
      result_o = RES_NC;
    end else if (a_i == b_i) begin
      result_o = RES_DRAW;
    end else if ((a_i == MV_ROCK     && b_i == MV_SCISSORS) ||
                 (a_i == MV_SCISSORS && b_i == MV_PAPER)    ||
                 (a_i == MV_PAPER    && b_i == MV_ROCK)) begin
      result_o = RES_P1;
    end
  end

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors match controller: sequences rounds against an external
// timer, scores them, ends the match at WIN_ROUNDS. Macro RPS_TIMEOUT_FORFEIT_EN.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_ROUNDS = 3,
  parameter int SCORE_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  rps_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_CLEAR   = ST_CLEAR;
  localparam logic [2:0] S_ARM     = ST_ARM;
  localparam logic [2:0] S_COLLECT = ST_COLLECT;
  localparam logic [2:0] S_JUDGE   = ST_JUDGE;
  localparam logic [2:0] S_OVER    = ST_OVER;

  localparam logic [SCORE_W-1:0] WIN_L = SCORE_W'(WIN_ROUNDS);
  localparam logic [SCORE_W-1:0] ONE_L = SCORE_W'(1);

  logic [2:0]         state_q, state_d;
  move_t              p1_q, p1_d, p2_q, p2_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  result_t            res_q, res_d;
  winner_t            win_q, win_d;
  result_t            judged;
  result_t            round_res;
  logic [SCORE_W-1:0] score1_inc, score2_inc;

  // A lock is simply a non-NONE stored move, so the judge sees unlocked sides as NONE.
  rps_judge u_judge (
    .a_i      (p1_q),
    .b_i      (p2_q),
    .result_o (judged)
  );

  always_comb begin
    round_res = judged;
`ifdef RPS_TIMEOUT_FORFEIT_EN
    if (p1_q != MV_NONE && p2_q == MV_NONE) begin
      round_res = RES_P1;
    end else if (p1_q == MV_NONE && p2_q != MV_NONE) begin
      round_res = RES_P2;
    end
`endif
  end

  assign score1_inc = score1_q + ONE_L;
  assign score2_inc = score2_q + ONE_L;

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    score1_d = score1_q;
    score2_d = score2_q;
    res_d    = res_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d  = S_CLEAR;
          score1_d = '0;
          score2_d = '0;
          win_d    = WN_NONE;
        end
      end
      S_CLEAR: begin
        p1_d    = MV_NONE;
        p2_d    = MV_NONE;
        state_d = S_ARM;
      end
      S_ARM: begin
        // The timer reports done while idle; wait until it is actually counting.
        if (!bus.timer_done) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (p1_q == MV_NONE && bus.p1_valid && bus.p1_move != MV_NONE)
          p1_d = move_t'(bus.p1_move);
        if (p2_q == MV_NONE && bus.p2_valid && bus.p2_move != MV_NONE)
          p2_d = move_t'(bus.p2_move);
        if ((p1_d != MV_NONE && p2_d != MV_NONE) || bus.timer_done)
          state_d = S_JUDGE;
      end
      S_JUDGE: begin
        res_d   = round_res;
        state_d = S_CLEAR;
        if (round_res == RES_P1) begin
          score1_d = score1_inc;
          if (score1_inc == WIN_L) begin
            state_d = S_OVER;
            win_d   = WN_P1;
          end
        end else if (round_res == RES_P2) begin
          score2_d = score2_inc;
          if (score2_inc == WIN_L) begin
            state_d = S_OVER;
            win_d   = WN_P2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      p1_q     <= MV_NONE;
      p2_q     <= MV_NONE;
      score1_q <= '0;
      score2_q <= '0;
      res_q    <= RES_DRAW;
      win_q    <= WN_NONE;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      res_q    <= res_d;
      win_q    <= win_d;
    end
  end

  assign bus.timer_clr    = (state_q == S_CLEAR);
  assign bus.timer_in     = (state_q == S_ARM) || (state_q == S_COLLECT);
  assign bus.result_valid = (state_q == S_JUDGE);
  assign bus.round_result = (state_q == S_JUDGE) ? round_res : res_q;
  assign bus.match_over   = (state_q == S_OVER);
  assign bus.winner       = win_q;
  assign bus.score1       = score1_q;
  assign bus.score2       = score2_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: inputs driven and outputs sampled on negedge.
module tb_rps_round_ctrl;

  localparam int SCORE_W = 4;

  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, ARM = 3'd2,
                         COLLECT = 3'd3, JUDGE = 3'd4, OVER = 3'd5;
  localparam logic [1:0] ROCK = 2'b01, PAPER = 2'b10, SCISSORS = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_s1   = 0;
  int   exp_s2   = 0;

  rps_round_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  rps_round_ctrl #(.WIN_ROUNDS(3), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_moves(input logic v1, input logic [1:0] m1,
                             input logic v2, input logic [1:0] m2);
    bus.p1_valid = v1; bus.p1_move = m1;
    bus.p2_valid = v2; bus.p2_move = m2;
  endtask

  // From a visible CLEAR cycle, walk through ARM into COLLECT.
  task automatic go_to_collect();
    chk("clear_state", 32'(bus.dbg_state), 32'(CLEAR));
    chk("clear_clr", 32'(bus.timer_clr), 1);
    chk("clear_tin", 32'(bus.timer_in), 0);
    tick();
    chk("arm_state", 32'(bus.dbg_state), 32'(ARM));
    chk("arm_tin", 32'(bus.timer_in), 1);
    chk("arm_clr", 32'(bus.timer_clr), 0);
    tick();
    chk("arm_hold", 32'(bus.dbg_state), 32'(ARM));
    bus.timer_done = 1'b0;
    tick();
    chk("collect_state", 32'(bus.dbg_state), 32'(COLLECT));
  endtask

  // In a JUDGE cycle: check result, let the timer go idle, step past JUDGE.
  task automatic judge_step(input logic [1:0] exp_res);
    chk("judge_state", 32'(bus.dbg_state), 32'(JUDGE));
    chk("judge_rv", 32'(bus.result_valid), 1);
    chk("judge_res", 32'(bus.round_result), 32'(exp_res));
    chk("judge_tin", 32'(bus.timer_in), 0);
    drive_moves(1'b0, 2'b00, 1'b0, 2'b00);
    bus.timer_done = 1'b1;
    if (exp_res == 2'b01) exp_s1++;
    if (exp_res == 2'b10) exp_s2++;
    tick();
    chk("post_rv", 32'(bus.result_valid), 0);
    chk("post_s1", 32'(bus.score1), 32'(exp_s1));
    chk("post_s2", 32'(bus.score2), 32'(exp_s2));
  endtask

  initial begin
    logic [1:0] one_move_res;
`ifdef RPS_TIMEOUT_FORFEIT_EN
    one_move_res = 2'b01;
`else
    one_move_res = 2'b11;
`endif
    reset = 1'b1;
    bus.start = 1'b0;
    bus.timer_done = 1'b1;
    drive_moves(1'b0, 2'b00, 1'b0, 2'b00);
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_s1", 32'(bus.score1), 0);
    chk("rst_s2", 32'(bus.score2), 0);
    chk("rst_res", 32'(bus.round_result), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_tin", 32'(bus.timer_in), 0);
    chk("rst_clr", 32'(bus.timer_clr), 0);
    chk("rst_over", 32'(bus.match_over), 0);
    chk("rst_win", 32'(bus.winner), 0);

    // Moves in IDLE are ignored; start opens the match.
    drive_moves(1'b1, ROCK, 1'b1, PAPER);
    tick();
    chk("idle_ignore", 32'(bus.dbg_state), 32'(IDLE));
    drive_moves(1'b0, 2'b00, 1'b0, 2'b00);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    // Rock beats scissors, both locked in one cycle.
    go_to_collect();
    drive_moves(1'b1, ROCK, 1'b1, SCISSORS);
    tick();
    judge_step(2'b01);
    chk("p1win_res_hold", 32'(bus.round_result), 32'(2'b01));

    // Paper/paper draw; valid with move 00 and a late second valid are ignored.
    go_to_collect();
    drive_moves(1'b1, 2'b00, 1'b0, 2'b00);
    tick();
    chk("none_ignored", 32'(bus.dbg_state), 32'(COLLECT));
    drive_moves(1'b1, PAPER, 1'b0, 2'b00);
    tick();
    chk("one_lock_wait", 32'(bus.dbg_state), 32'(COLLECT));
    drive_moves(1'b1, ROCK, 1'b1, PAPER);
    tick();
    judge_step(2'b00);
    chk("draw_replay", 32'(bus.dbg_state), 32'(CLEAR));

    // Only p1 moves, then timeout.
    go_to_collect();
    drive_moves(1'b1, ROCK, 1'b0, 2'b00);
    tick();
    drive_moves(1'b0, 2'b00, 1'b0, 2'b00);
    bus.timer_done = 1'b1;
    tick();
    judge_step(one_move_res);

    // No moves at all, timeout.
    go_to_collect();
    bus.timer_done = 1'b1;
    tick();
    judge_step(2'b11);

    // p2 locks in the same cycle the timer expires; p1 already locked.
    go_to_collect();
    drive_moves(1'b1, SCISSORS, 1'b0, 2'b00);
    tick();
    drive_moves(1'b0, 2'b00, 1'b1, ROCK);
    bus.timer_done = 1'b1;
    tick();
    judge_step(2'b10);

    // p1 takes rounds until the match ends.
    for (int r = 0; r < 3 && exp_s1 < 3; r++) begin
      go_to_collect();
      drive_moves(1'b1, PAPER, 1'b1, ROCK);
      tick();
      judge_step(2'b01);
      chk("after_round", 32'(bus.dbg_state), (exp_s1 == 3) ? 32'(OVER) : 32'(CLEAR));
    end
    chk("over_flag", 32'(bus.match_over), 1);
    chk("over_winner", 32'(bus.winner), 32'(2'b01));
    chk("over_tin", 32'(bus.timer_in), 0);
    tick();
    chk("over_hold", 32'(bus.dbg_state), 32'(OVER));
    chk("over_s1_hold", 32'(bus.score1), 3);
    chk("over_win_hold", 32'(bus.winner), 32'(2'b01));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_s1 = 0; exp_s2 = 0;
    chk("restart_s1", 32'(bus.score1), 0);
    chk("restart_s2", 32'(bus.score2), 0);
    chk("restart_over", 32'(bus.match_over), 0);
    chk("restart_win", 32'(bus.winner), 0);

    // Reset mid-round with p1 locked, start asserted alongside.
    go_to_collect();
    drive_moves(1'b1, ROCK, 1'b0, 2'b00);
    tick();
    drive_moves(1'b0, 2'b00, 1'b0, 2'b00);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("mid_rst_rv", 32'(bus.result_valid), 0);
    chk("mid_rst_res", 32'(bus.round_result), 0);
    chk("mid_rst_tin", 32'(bus.timer_in), 0);
    chk("mid_rst_clr", 32'(bus.timer_clr), 0);
    chk("mid_rst_s1", 32'(bus.score1), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("mid_rst_idle", 32'(bus.dbg_state), 32'(IDLE));
    chk("mid_rst_rv2", 32'(bus.result_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
